// File: rtl/fp_addsub_sched_if.sv
// Bundle of request, datapath and response signals for the shared FP add/sub scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface fp_addsub_sched_if #(
    parameter int TAG_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [31:0]       req0_a;
    logic [31:0]       req0_b;
    logic              req0_op;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [31:0]       req1_a;
    logic [31:0]       req1_b;
    logic              req1_op;
    logic [TAG_W-1:0]  req1_tag;

    logic              dp_sign1;
    logic              dp_sign2;
    logic [7:0]        dp_exp1;
    logic [7:0]        dp_exp2;
    logic [22:0]       dp_sig1;
    logic [22:0]       dp_sig2;
    logic              dp_opcode;
    logic [31:0]       dp_fp_out;
    logic [2:0]        dp_error;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [TAG_W-1:0]  resp_tag;
    logic [31:0]       resp_result;
    logic [2:0]        resp_error;

    logic              busy;
    logic [15:0]       done_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
        output req0_ready, req1_ready,
        output dp_sign1, dp_sign2, dp_exp1, dp_exp2, dp_sig1, dp_sig2, dp_opcode,
        input  dp_fp_out, dp_error,
        output resp_valid, resp_id, resp_tag, resp_result, resp_error,
        input  resp_ready,
        output busy, done_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_tag,
        output req1_valid, req1_a, req1_b, req1_op, req1_tag,
        input  req0_ready, req1_ready,
        input  dp_sign1, dp_sign2, dp_exp1, dp_exp2, dp_sig1, dp_sig2, dp_opcode,
        output dp_fp_out, dp_error,
        input  resp_valid, resp_id, resp_tag, resp_result, resp_error,
        output resp_ready,
        input  busy, done_count
    );
endinterface

// File: rtl/fp_addsub_sched.sv
// Round-robin sequencer sharing one multicycle combinational FP add/sub datapath between
// two requesters; operands are held for SETTLE_CYCLES before the result is sampled.
module fp_addsub_sched #(
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_addsub_sched_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t            state;
    logic              last_grant;
    logic [3:0]        cnt;
    logic              grant;
    logic              accept;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic              sel_op;
    logic [TAG_W-1:0]  sel_tag;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    assign bus.req0_ready = (state == IDLE) && !reset && bus.req0_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && !reset && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
    assign sel_b   = grant ? bus.req1_b   : bus.req0_b;
    assign sel_op  = grant ? bus.req1_op  : bus.req0_op;
    assign sel_tag = grant ? bus.req1_tag : bus.req0_tag;

    assign bus.busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            cnt             <= '0;
            bus.dp_sign1    <= 1'b0;
            bus.dp_sign2    <= 1'b0;
            bus.dp_exp1     <= '0;
            bus.dp_exp2     <= '0;
            bus.dp_sig1     <= '0;
            bus.dp_sig2     <= '0;
            bus.dp_opcode   <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_id     <= 1'b0;
            bus.resp_tag    <= '0;
            bus.resp_result <= '0;
            bus.resp_error  <= '0;
            bus.done_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bus.dp_sign1  <= sel_a[31];
                        bus.dp_exp1   <= sel_a[30:23];
                        bus.dp_sig1   <= sel_a[22:0];
                        bus.dp_sign2  <= sel_b[31];
                        bus.dp_exp2   <= sel_b[30:23];
                        bus.dp_sig2   <= sel_b[22:0];
                        bus.dp_opcode <= sel_op;
                        bus.resp_id   <= grant;
                        bus.resp_tag  <= sel_tag;
                        last_grant    <= grant;
                        cnt           <= CNT_INIT;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Datapath inputs stay frozen; sample once the multicycle path has settled.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.resp_result <= bus.dp_fp_out;
                        bus.resp_error  <= bus.dp_error;
                        bus.resp_valid  <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.done_count <= bus.done_count + 16'd1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a behavioural datapath stands in for the FP unit and a
// scoreboard queue pairs each accepted request with the response it must produce.
module tb_fp_addsub_sched;
    localparam int TAG_W  = 4;
    localparam int SETTLE = 2;

    typedef struct {
        logic              id;
        logic [TAG_W-1:0]  tag;
        logic [31:0]       result;
        logic [2:0]        error;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];

    fp_addsub_sched_if #(.TAG_W(TAG_W)) bus ();

    fp_addsub_sched #(.TAG_W(TAG_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in datapath: a few known FP results, a NaN case with an error code, else an integer mix.
    function automatic logic [34:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h7FC0_0000)
            return {3'b010, 32'h7FC0_0000};
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op)
            return {3'b000, 32'h4040_0000};
        return {3'b000, op ? (a - b) : (a + b)};
    endfunction

    assign {bus.dp_error, bus.dp_fp_out} =
        dp_model({bus.dp_sign1, bus.dp_exp1, bus.dp_sig1},
                 {bus.dp_sign2, bus.dp_exp2, bus.dp_sig2}, bus.dp_opcode);

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [TAG_W-1:0] tag);
        logic [34:0] r;
        exp_t e;
        r = dp_model(a, b, op);
        e.id = id; e.tag = tag; e.result = r[31:0]; e.error = r[34:32];
        sb.push_back(e);
    endtask

    // Scoreboard: push on accept, pop and compare on each response handshake.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (bus.req0_valid && bus.req0_ready)
                push(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_tag);
            if (bus.req1_valid && bus.req1_ready)
                push(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_tag);
            if (bus.resp_valid && bus.resp_ready) begin
                check("resp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_id",     32'(bus.resp_id),     32'(e.id));
                    check("resp_tag",    32'(bus.resp_tag),    32'(e.tag));
                    check("resp_result", bus.resp_result,      e.result);
                    check("resp_error",  32'(bus.resp_error),  32'(e.error));
                end
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 of the cycle whose next edge accepts.
    task automatic wait_ready(input logic id, input string name);
        int n;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_ready_timeout"}, 32'(n < 30), 32'd1);
    endtask

    // Drives one request and returns at the negedge just after the accept edge.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [TAG_W-1:0] tag, input string name);
        @(negedge clk);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_tag = tag; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_tag = tag; bus.req0_valid = 1'b1;
        end
        #1;
        wait_ready(id, name);
        @(negedge clk);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // Called at negedge+1 after the accept edge; counts edges until resp_valid rises.
    task automatic settle_latency(input string name);
        int n;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(SETTLE));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while ((sb.size() != 0 || bus.busy) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0; bus.req1_tag = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_done",       32'(bus.done_count), 32'd0);
        check("rst_dp_exp1",    32'(bus.dp_exp1),    32'd0);
        check("rst_dp_sig2",    32'(bus.dp_sig2),    32'd0);
        check("rst_resp_tag",   32'(bus.resp_tag),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single op on req0: 1.0 + 2.0
        issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, "single");
        #1;
        check("single_ready_low", 32'(bus.req0_ready), 32'd0);
        check("single_busy",      32'(bus.busy),       32'd1);
        settle_latency("single");
        check("single_result", bus.resp_result,      32'h4040_0000);
        check("single_id",     32'(bus.resp_id),     32'd0);
        check("single_tag",    32'(bus.resp_tag),    32'd5);
        @(negedge clk); #1;
        check("single_done",   32'(bus.done_count),  32'd1);
        check("single_idle",   32'(bus.busy),        32'd0);

        // Operand field mapping on req1
        issue(1'b1, 32'hC120_0000, 32'h0000_0001, 1'b1, 4'd3, "fields");
        #1;
        check("map_sign1",  32'(bus.dp_sign1),  32'd1);
        check("map_exp1",   32'(bus.dp_exp1),   32'h82);
        check("map_sig1",   32'(bus.dp_sig1),   32'h20_0000);
        check("map_sign2",  32'(bus.dp_sign2),  32'd0);
        check("map_exp2",   32'(bus.dp_exp2),   32'd0);
        check("map_sig2",   32'(bus.dp_sig2),   32'h00_0001);
        check("map_opcode", 32'(bus.dp_opcode), 32'd1);
        settle_latency("fields");
        drain("fields");
        check("fields_done", 32'(bus.done_count), 32'd2);

        // Backpressure: consumer stalls 10 cycles while req1 waits
        @(negedge clk);
        bus.resp_ready = 1'b0;
        issue(1'b0, 32'h40A0_0000, 32'h3F80_0000, 1'b1, 4'd7, "bp");
        #1;
        settle_latency("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.req1_a = 32'h0000_0010; bus.req1_b = 32'h0000_0020; bus.req1_op = 1'b0;
                bus.req1_tag = 4'd9; bus.req1_valid = 1'b1;
            end
            #1;
            check("bp_valid",   32'(bus.resp_valid),  32'd1);
            check("bp_result",  bus.resp_result,      32'h40A0_0000 - 32'h3F80_0000);
            check("bp_tag",     32'(bus.resp_tag),    32'd7);
            check("bp_dp_exp1", 32'(bus.dp_exp1),     32'h81);
            check("bp_ready0",  32'(bus.req0_ready),  32'd0);
            check("bp_ready1",  32'(bus.req1_ready),  32'd0);
            check("bp_busy",    32'(bus.busy),        32'd1);
            check("bp_done",    32'(bus.done_count),  32'd2);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #1;
        wait_ready(1'b1, "bp_req1");
        @(negedge clk);
        bus.req1_valid = 1'b0;
        drain("bp");
        check("bp_done_after", 32'(bus.done_count), 32'd4);

        // Reset one edge into SETTLE discards the op
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd2, "rst_mid");
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        check("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstmid_busy",       32'(bus.busy),       32'd0);
        check("rstmid_done",       32'(bus.done_count), 32'd0);
        check("rstmid_dp_exp1",    32'(bus.dp_exp1),    32'd0);
        check("rstmid_dp_sig1",    32'(bus.dp_sig1),    32'd0);
        check("rstmid_resp_tag",   32'(bus.resp_tag),   32'd0);

        // Contention from reset: both valid throughout, service must alternate starting at req0
        @(negedge clk);
        bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h3F80_0000; bus.req0_op = 1'b1; bus.req0_tag = 4'hA;
        bus.req1_a = 32'h4100_0000; bus.req1_b = 32'h4000_0000; bus.req1_op = 1'b0; bus.req1_tag = 4'hB;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            #1;
            while (!(bus.req0_ready || bus.req1_ready) && n < 30) begin
                @(negedge clk); #1;
                n++;
            end
            check("cont_timeout",  32'(n < 30),                            32'd1);
            check("cont_one_hot",  32'(bus.req0_ready && bus.req1_ready),   32'd0);
            check("cont_grant_id", 32'(bus.req1_ready),                    32'(i % 2));
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain("cont");
        check("cont_done", 32'(bus.done_count), 32'd4);

        // Datapath error passes through untouched
        issue(1'b1, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 4'hC, "err");
        #1;
        settle_latency("err");
        check("err_result", bus.resp_result,      32'h7FC0_0000);
        check("err_code",   32'(bus.resp_error),  32'b010);
        drain("err");
        check("err_done",   32'(bus.done_count),  32'd5);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
